// File: rtl/packet_reassembler_if.sv
// Flit-in / packet-out bus of the packet reassembler.
//   input_data/valid_in          : flits from the router core port
//   packet_out/node_start_out/
//   packet_id_out/valid_out      : head of the completed-packet queue
//   ready_in                     : consumer pop request
// master drives flits and consumes packets; slave is the reassembler.
interface packet_reassembler_if #(
    parameter int unsigned NODE_COUNT      = 9,
    parameter int unsigned PACKET_ID_WIDTH = 5
);
    localparam int unsigned NW = $clog2(NODE_COUNT);
    localparam int unsigned FW = 1 + 2 * NW + 8 + PACKET_ID_WIDTH + 2;

    logic [FW-1:0]              input_data;
    logic                       valid_in;
    logic [31:0]                packet_out;
    logic [NW-1:0]              node_start_out;
    logic [PACKET_ID_WIDTH-1:0] packet_id_out;
    logic                       valid_out;
    logic                       ready_in;

    modport master (
        output input_data, valid_in, ready_in,
        input  packet_out, node_start_out, packet_id_out, valid_out
    );

    modport slave (
        input  input_data, valid_in, ready_in,
        output packet_out, node_start_out, packet_id_out, valid_out
    );
endinterface

// File: rtl/packet_reassembler.sv
// Receive-side NoC endpoint: rebuilds 32-bit packets from 8-bit flits in per-source slots
// and queues completed packets in a FIFO.
//   clk, rst (sync, active high), ce (clock enable)
//   bus       : packet_reassembler_if.slave (flit input, packet output handshake)
//   busy_out  : FIFO full (registered)
//   pkt_count : packets pushed into the FIFO, saturating
//   err_count : error events, saturating
// Optional macro REASSEMBLER_STATS_EN: enables the counters and per-source id sequence
// checking; without it both counters are tied to zero.
module packet_reassembler #(
    parameter int unsigned NODE_ID         = 0,
    parameter int unsigned NODE_COUNT      = 9,
    parameter int unsigned QUEUE_DEPTH     = 8,
    parameter int unsigned PACKET_ID_WIDTH = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    packet_reassembler_if.slave bus,
    output logic                busy_out,
    output logic [15:0]         pkt_count,
    output logic [15:0]         err_count
);
    localparam int unsigned NW   = $clog2(NODE_COUNT);
    localparam int unsigned PW   = PACKET_ID_WIDTH;
    localparam int unsigned AW   = $clog2(QUEUE_DEPTH);
    localparam int unsigned EW   = 32 + NW + PW;
    localparam int unsigned CW   = AW + 1;

    logic          flit_vld;
    logic [NW-1:0] flit_src;
    logic [NW-1:0] flit_dst;
    logic [PW-1:0] flit_id;
    logic [1:0]    flit_frag;
    logic [7:0]    flit_data;

    assign {flit_vld, flit_src, flit_dst, flit_id, flit_frag, flit_data} = bus.input_data;

    // Reassembly slots, one per source
    logic          slot_busy_q [NODE_COUNT];
    logic          slot_busy_d [NODE_COUNT];
    logic [PW-1:0] slot_id_q   [NODE_COUNT];
    logic [PW-1:0] slot_id_d   [NODE_COUNT];
    logic [3:0]    slot_mask_q [NODE_COUNT];
    logic [3:0]    slot_mask_d [NODE_COUNT];
    logic [31:0]   slot_buf_q  [NODE_COUNT];
    logic [31:0]   slot_buf_d  [NODE_COUNT];

    // Output FIFO
    logic [EW-1:0] mem_q [QUEUE_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          busy_q, busy_d;

    logic          flit_take, pop, push, full, err_ev, slot_we;
    logic          cur_busy, nxt_busy;
    logic [PW-1:0] cur_id, nxt_id;
    logic [3:0]    cur_mask, nxt_mask, frag_oh;
    logic [31:0]   cur_buf, nxt_buf;
    logic [EW-1:0] push_entry;

    always_comb begin
        flit_take = ce & bus.valid_in & flit_vld;
        pop       = ce & (count_q != '0) & bus.ready_in;
        full      = (count_q == CW'(QUEUE_DEPTH));
        frag_oh   = 4'b0001 << flit_frag;

        cur_busy = 1'b0;
        cur_id   = '0;
        cur_mask = '0;
        cur_buf  = '0;
        for (int s = 0; s < NODE_COUNT; s++) begin
            if (flit_src == NW'(s)) begin
                cur_busy = slot_busy_q[s];
                cur_id   = slot_id_q[s];
                cur_mask = slot_mask_q[s];
                cur_buf  = slot_buf_q[s];
            end
        end

        nxt_busy = cur_busy;
        nxt_id   = cur_id;
        nxt_mask = cur_mask;
        nxt_buf  = cur_buf;
        slot_we  = 1'b0;
        err_ev   = 1'b0;
        push     = 1'b0;

        if (flit_take) begin
            if (flit_dst != NW'(NODE_ID) || 32'(flit_src) >= NODE_COUNT) begin
                err_ev = 1'b1;
            end else begin
                slot_we = 1'b1;
                if (!cur_busy || cur_id != flit_id) begin
                    // Idle slot, or a new id evicting an unfinished packet
                    err_ev   = cur_busy;
                    nxt_busy = 1'b1;
                    nxt_id   = flit_id;
                    nxt_mask = frag_oh;
                end else if ((cur_mask & frag_oh) != '0) begin
                    err_ev  = 1'b1;
                    slot_we = 1'b0;
                end else begin
                    nxt_mask = cur_mask | frag_oh;
                end
                nxt_buf[{flit_frag, 3'b000} +: 8] = flit_data;
                if (slot_we && nxt_mask == 4'b1111) begin
                    nxt_busy = 1'b0;
                    nxt_mask = '0;
                    // A same-cycle pop frees the entry we need
                    if (!full || pop) push = 1'b1;
                    else              err_ev = 1'b1;
                end
            end
        end

        push_entry = {nxt_buf, flit_src, flit_id};

        for (int s = 0; s < NODE_COUNT; s++) begin
            slot_busy_d[s] = slot_busy_q[s];
            slot_id_d[s]   = slot_id_q[s];
            slot_mask_d[s] = slot_mask_q[s];
            slot_buf_d[s]  = slot_buf_q[s];
            if (slot_we && flit_src == NW'(s)) begin
                slot_busy_d[s] = nxt_busy;
                slot_id_d[s]   = nxt_id;
                slot_mask_d[s] = nxt_mask;
                slot_buf_d[s]  = nxt_buf;
            end
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        busy_d   = (count_d == CW'(QUEUE_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NODE_COUNT; s++) begin
                slot_busy_q[s] <= 1'b0;
                slot_id_q[s]   <= '0;
                slot_mask_q[s] <= '0;
                slot_buf_q[s]  <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            slot_busy_q <= slot_busy_d;
            slot_id_q   <= slot_id_d;
            slot_mask_q <= slot_mask_d;
            slot_buf_q  <= slot_buf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while the queue is empty
    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q] <= push_entry;
    end

    logic [EW-1:0] head;
    assign head               = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign bus.valid_out      = (count_q != '0);
    assign bus.packet_out     = head[EW-1 -: 32];
    assign bus.node_start_out = head[PW +: NW];
    assign bus.packet_id_out  = head[PW-1:0];
    assign busy_out           = busy_q;

`ifdef REASSEMBLER_STATS_EN
    logic [PW-1:0] exp_id_q [NODE_COUNT];
    logic [PW-1:0] exp_id_d [NODE_COUNT];
    logic [15:0]   pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;
    logic [PW-1:0] cur_exp;
    logic          seq_err;

    always_comb begin
        cur_exp = '0;
        for (int s = 0; s < NODE_COUNT; s++) begin
            exp_id_d[s] = exp_id_q[s];
            if (flit_src == NW'(s)) cur_exp = exp_id_q[s];
        end
        // Sequence is tracked only for packets that actually enter the queue
        seq_err = push && (cur_exp != flit_id);
        for (int s = 0; s < NODE_COUNT; s++) begin
            if (push && flit_src == NW'(s)) exp_id_d[s] = flit_id + PW'(1);
        end
        pkt_cnt_d = pkt_cnt_q;
        err_cnt_d = err_cnt_q;
        if (push && pkt_cnt_q != 16'hFFFF)                err_cnt_d = err_cnt_q;
        if (push && pkt_cnt_q != 16'hFFFF)                pkt_cnt_d = pkt_cnt_q + 16'd1;
        if ((err_ev || seq_err) && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NODE_COUNT; s++) exp_id_q[s] <= '0;
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            exp_id_q  <= exp_id_d;
            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign pkt_count = pkt_cnt_q;
    assign err_count = err_cnt_q;
`else
    assign pkt_count = 16'd0;
    assign err_count = 16'd0;
`endif
endmodule
